// File: rtl/dms_cp_ctrl.sv
// Charge-pump sequencer for the CDR loop: arbitrates PFD requests into pump
// commands, caps runaway pulses and runs an activity-based acquire/track lock FSM.
//
// state   | meaning
// --------+-------------------------------------------------------------
// IDLE    | loop disabled, pump gated off, all counters cleared
// ACQUIRE | high-gain pump, counting consecutive quiet windows
// TRACK   | locked, low-gain pump, watching for excessive pump activity
module dms_cp_ctrl #(
   parameter int unsigned PULSE_MAX  = 15,
   parameter int unsigned LOCK_WIN   = 64,
   parameter int unsigned LOCK_THR   = 4,
   parameter int unsigned UNLOCK_THR = 16,
   parameter int unsigned LOCK_CNT   = 4
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       en,
   input  logic       pfd_up,
   input  logic       pfd_dn,
   output logic       up,
   output logic       down,
   output logic       fast,
   output logic       locked,
   output logic [1:0] state
);

   localparam int unsigned RUN_W = $clog2(PULSE_MAX + 1);
   localparam int unsigned WIN_W = $clog2(LOCK_WIN);
   localparam int unsigned ACT_W = $clog2(LOCK_WIN + 1);
   localparam int unsigned Q_W   = $clog2(LOCK_CNT + 1);

   localparam logic [RUN_W-1:0] RUN_MAX    = RUN_W'(PULSE_MAX);
   localparam logic [WIN_W-1:0] WIN_LAST   = WIN_W'(LOCK_WIN - 1);
   localparam logic [ACT_W-1:0] ACT_MAX    = ACT_W'(LOCK_WIN);
   localparam logic [ACT_W-1:0] ACT_LOCK   = ACT_W'(LOCK_THR);
   localparam logic [ACT_W-1:0] ACT_UNLOCK = ACT_W'(UNLOCK_THR);
   localparam logic [Q_W-1:0]   Q_MAX      = Q_W'(LOCK_CNT);

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_ACQ  = 2'd1,
      ST_TRK  = 2'd2
   } state_t;

   state_t           r_state;
   logic             r_up;
   logic             r_dn;
   logic             r_fast;
   logic             r_locked;
   logic             r_prev_up;
   logic             r_prev_dn;
   logic [RUN_W-1:0] r_run;
   logic [WIN_W-1:0] r_win;
   logic [ACT_W-1:0] r_act;
   logic [Q_W-1:0]   r_quiet;

   logic             w_req_up;
   logic             w_req_dn;
   logic             w_same;
   logic [RUN_W-1:0] w_run_base;
   logic             w_run_ok;
   logic             w_active;
   logic [ACT_W-1:0] w_act_now;
   logic             w_win_end;
   logic             w_loud;
   logic [Q_W-1:0]   w_quiet_next;

   assign w_req_up   = pfd_up & ~pfd_dn;
   assign w_req_dn   = pfd_dn & ~pfd_up;
   // A run continues only while the same single direction is requested back to back.
   assign w_same     = (w_req_up & r_prev_up) | (w_req_dn & r_prev_dn);
   assign w_run_base = w_same ? r_run : '0;
   assign w_run_ok   = (w_run_base < RUN_MAX);

   // Window activity includes the pump state of the current cycle.
   assign w_active   = r_up | r_dn;
   assign w_act_now  = (r_act == ACT_MAX) ? r_act : r_act + ACT_W'(w_active);
   assign w_win_end  = (r_win == WIN_LAST);
   assign w_loud     = (w_act_now > ACT_UNLOCK);

   always_comb begin
      w_quiet_next = '0;
      if (w_act_now <= ACT_LOCK) begin
         w_quiet_next = (r_quiet == Q_MAX) ? r_quiet : r_quiet + Q_W'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n || !en) begin
         r_state   <= ST_IDLE;
         r_up      <= 1'b0;
         r_dn      <= 1'b0;
         r_fast    <= 1'b0;
         r_locked  <= 1'b0;
         r_prev_up <= 1'b0;
         r_prev_dn <= 1'b0;
         r_run     <= '0;
         r_win     <= '0;
         r_act     <= '0;
         r_quiet   <= '0;
      end else if (r_state == ST_IDLE) begin
         r_state   <= ST_ACQ;
         r_up      <= 1'b0;
         r_dn      <= 1'b0;
         r_fast    <= 1'b1;
         r_locked  <= 1'b0;
         r_prev_up <= 1'b0;
         r_prev_dn <= 1'b0;
         r_run     <= '0;
         r_win     <= '0;
         r_act     <= '0;
         r_quiet   <= '0;
      end else begin
         r_prev_up <= w_req_up;
         r_prev_dn <= w_req_dn;
         if ((w_req_up || w_req_dn) && w_run_ok) begin
            r_up  <= w_req_up;
            r_dn  <= w_req_dn;
            r_run <= w_run_base + RUN_W'(1);
         end else begin
            r_up  <= 1'b0;
            r_dn  <= 1'b0;
            r_run <= (w_req_up || w_req_dn) ? w_run_base : '0;
         end

         if (w_win_end) begin
            r_win   <= '0;
            r_act   <= '0;
            r_quiet <= w_quiet_next;
            if (r_state == ST_ACQ && w_quiet_next == Q_MAX) begin
               r_state  <= ST_TRK;
               r_fast   <= 1'b0;
               r_locked <= 1'b1;
            end else if (r_state == ST_TRK && w_loud) begin
               r_state  <= ST_ACQ;
               r_fast   <= 1'b1;
               r_locked <= 1'b0;
               r_quiet  <= '0;
            end
         end else begin
            r_win <= r_win + WIN_W'(1);
            r_act <= w_act_now;
         end
      end
   end

   assign up     = r_up;
   assign down   = r_dn;
   assign fast   = r_fast;
   assign locked = r_locked;
   assign state  = r_state;

endmodule

// File: tb/tb_dms_cp_ctrl.sv
// Bench for dms_cp_ctrl: a vector table for reset, arbitration and pulse capping,
// then a long cycle-indexed sequence for lock acquire/loss and disable/re-enable.
module tb_dms_cp_ctrl;

   logic       clk;
   logic       rst_n;
   logic       en;
   logic       pfd_up;
   logic       pfd_dn;
   logic       up;
   logic       down;
   logic       fast;
   logic       locked;
   logic [1:0] state;

   int checks;
   int failures;

   typedef struct {
      logic       r;
      logic       e;
      logic       pu;
      logic       pd;
      logic [5:0] exp;
      string      name;
   } vec_t;

   typedef struct {
      logic [5:0] exp;
      string      name;
   } sb_t;

   vec_t vecs[$];
   sb_t  sb[$];

   dms_cp_ctrl dut (
      .clk    (clk),
      .rst_n  (rst_n),
      .en     (en),
      .pfd_up (pfd_up),
      .pfd_dn (pfd_dn),
      .up     (up),
      .down   (down),
      .fast   (fast),
      .locked (locked),
      .state  (state)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Expected output packing: {up, down, fast, locked, state[1:0]}
   localparam logic [5:0] O_RST  = 6'b000000;
   localparam logic [5:0] O_ACQ  = 6'b001001;
   localparam logic [5:0] O_AUP  = 6'b101001;
   localparam logic [5:0] O_ADN  = 6'b011001;
   localparam logic [5:0] O_TRK  = 6'b000110;
   localparam logic [5:0] O_TUP  = 6'b100110;

   task automatic add(input logic r, input logic e, input logic pu, input logic pd,
                      input logic [5:0] exp, input string name);
      vec_t v;
      v.r = r; v.e = e; v.pu = pu; v.pd = pd; v.exp = exp; v.name = name;
      vecs.push_back(v);
   endtask

   task automatic drive(input logic r, input logic e, input logic pu, input logic pd);
      @(negedge clk);
      rst_n  = r;
      en     = e;
      pfd_up = pu;
      pfd_dn = pd;
   endtask

   task automatic expect_out(input logic [5:0] exp, input string name);
      sb_t s;
      s.exp = exp; s.name = name;
      sb.push_back(s);
   endtask

   task automatic settle_and_compare();
      sb_t        s;
      logic [5:0] got;
      @(posedge clk);
      #1;
      if (sb.size() != 0) begin
         s   = sb.pop_front();
         got = {up, down, fast, locked, state};
         checks++;
         if (got !== s.exp) begin
            failures++;
            $display("FAIL %s got=%b exp=%b (up,dn,fast,locked,state)", s.name, got, s.exp);
         end
      end
   endtask

   function automatic logic long_pu(input int n);
      logic pu;
      pu = 1'b0;
      if (n <= 192 && (n % 64 == 5 || n % 64 == 30)) pu = 1'b1;
      if (n == 197 || n == 210 || n == 222 || n == 240) pu = 1'b1;
      if (n >= 262 && n <= 271) pu = 1'b1;
      if (n >= 326 && n <= 337) pu = 1'b1;
      if (n >= 390 && n <= 401) pu = 1'b1;
      if (n >= 430 && n <= 433) pu = 1'b1;
      if (n == 447) pu = 1'b1;
      if (n >= 706 && n <= 710) pu = 1'b1;
      return pu;
   endfunction

   initial begin
      checks   = 0;
      failures = 0;
      rst_n    = 1'b0;
      en       = 1'b0;
      pfd_up   = 1'b0;
      pfd_dn   = 1'b0;

      for (int i = 0; i < 3; i++) add(0, 1, 1, 0, O_RST, "reset_hold");
      add(1, 1, 1, 0, O_ACQ, "enter_acquire");
      add(1, 1, 1, 0, O_AUP, "first_up");
      for (int i = 0; i < 5; i++) add(1, 1, 1, 1, O_ACQ, "cancel");
      for (int i = 0; i < 3; i++) add(1, 1, 0, 1, O_ADN, "down_only");
      add(1, 1, 0, 0, O_ACQ, "down_release");
      for (int i = 0; i < 40; i++) add(1, 1, 1, 0, (i < 15) ? O_AUP : O_ACQ, "limit_run");
      add(1, 1, 0, 0, O_ACQ, "limit_gap");
      for (int i = 0; i < 16; i++) add(1, 1, 1, 0, (i < 15) ? O_AUP : O_ACQ, "limit_rerun");
      add(1, 1, 0, 0, O_ACQ, "rerun_release");
      add(1, 1, 1, 0, O_AUP, "pulse_before_rst");
      add(0, 1, 1, 0, O_RST, "reset_mid_pulse");

      foreach (vecs[k]) begin
         drive(vecs[k].r, vecs[k].e, vecs[k].pu, vecs[k].pd);
         expect_out(vecs[k].exp, vecs[k].name);
         settle_and_compare();
      end

      drive(0, 1, 0, 0);
      settle_and_compare();

      // n = 0 is the edge that enters ACQUIRE; window k covers edges 64k+1 .. 64k+64.
      for (int n = 0; n <= 967; n++) begin
         drive(1'b1, (n != 710), long_pu(n), (n >= 350 && n <= 353));
         case (n)
            64:       expect_out(O_ACQ, "win1_still_acq");
            255:      expect_out(O_ACQ, "pre_lock");
            256:      expect_out(O_TRK, "lock_at_256");
            262:      expect_out(O_TUP, "track_pump");
            320:      expect_out(O_TRK, "ten_active_keeps");
            384:      expect_out(O_TRK, "sixteen_keeps");
            447:      expect_out(O_TUP, "pre_unlock");
            448:      expect_out(O_ACQ, "unlock_incl_last");
            703:      expect_out(O_ACQ, "relock_pending");
            704:      expect_out(O_TRK, "relock");
            709:      expect_out(O_TUP, "track_up_before_dis");
            710:      expect_out(O_RST, "disable_mid_pulse");
            711:      expect_out(O_ACQ, "reenable");
            966:      expect_out(O_ACQ, "reenable_pre_lock");
            967:      expect_out(O_TRK, "reenable_lock");
            default:  ;
         endcase
         settle_and_compare();
      end

      if (sb.size() != 0) begin
         checks++;
         failures++;
         $display("FAIL scoreboard_drain left=%0d required=0", sb.size());
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
